// File: rtl/sdm_tone_rx.sv
`default_nettype none
// ============================================================================
// Module   : sdm_tone_rx
// Purpose  : 2nd-order CIC decimator for a 1-bit sigma-delta tone, with an
//            optional hysteretic rising-crossing period meter enabled by
//            the SDM_TONE_RX_PERIOD_EN macro.
// Revision : 1.0
// ============================================================================
module sdm_tone_rx #(
    parameter int DECIM = 16,
    parameter int OUT_W = 8,
    parameter int PER_W = 16,
    parameter int HYST  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_valid,
    input  logic             sdm_in,
    output logic [OUT_W-1:0] sample_out,
    output logic             sample_valid,
    output logic [PER_W-1:0] period_out,
    output logic             period_valid,
    output logic             locked
);

    localparam int c_LOG2  = $clog2(DECIM);
    localparam int c_W     = 2 * c_LOG2 + 1;
    localparam int c_SHIFT = 2 * c_LOG2 - OUT_W;
    localparam logic [c_W-1:0] c_OUT_MAX = c_W'((1 << OUT_W) - 1);

    logic [c_W-1:0]    r_i1;
    logic [c_W-1:0]    r_i2;
    logic [c_W-1:0]    r_i2_saved;
    logic [c_W-1:0]    r_c1_saved;
    logic [c_LOG2-1:0] r_dec_cnt;
    logic [OUT_W-1:0]  r_sample;
    logic              r_sample_valid;

    logic [c_W-1:0]    w_i1_nxt;
    logic [c_W-1:0]    w_i2_nxt;
    logic [c_W-1:0]    w_c1;
    logic [c_W-1:0]    w_c2;
    logic [c_W-1:0]    w_r;
    logic [OUT_W-1:0]  w_sample;
    logic              w_frame_done;

    // I2 accumulates the already-updated I1; all differences wrap mod 2^W.
    always_comb begin
        w_i1_nxt = r_i1 + {{(c_W-1){1'b0}}, sdm_in};
        w_i2_nxt = r_i2 + w_i1_nxt;
        w_c1     = w_i2_nxt - r_i2_saved;
        w_c2     = w_c1 - r_c1_saved;
        w_r      = w_c2 >> c_SHIFT;
        w_sample = (w_r > c_OUT_MAX) ? {OUT_W{1'b1}} : w_r[OUT_W-1:0];
    end

    assign w_frame_done = bit_valid && (r_dec_cnt == c_LOG2'(DECIM - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_i1           <= '0;
            r_i2           <= '0;
            r_i2_saved     <= '0;
            r_c1_saved     <= '0;
            r_dec_cnt      <= '0;
            r_sample       <= '0;
            r_sample_valid <= 1'b0;
        end else begin
            r_sample_valid <= 1'b0;
            if (bit_valid) begin
                r_i1      <= w_i1_nxt;
                r_i2      <= w_i2_nxt;
                r_dec_cnt <= r_dec_cnt + 1'b1;
                if (w_frame_done) begin
                    r_i2_saved     <= w_i2_nxt;
                    r_c1_saved     <= w_c1;
                    r_sample       <= w_sample;
                    r_sample_valid <= 1'b1;
                end
            end
        end
    end

    assign sample_out   = r_sample;
    assign sample_valid = r_sample_valid;

`ifdef SDM_TONE_RX_PERIOD_EN
    localparam logic [0:0] S_WAIT_LOW  = 1'b0;
    localparam logic [0:0] S_WAIT_HIGH = 1'b1;
    localparam logic [OUT_W-1:0] c_LO = OUT_W'((1 << (OUT_W - 1)) - HYST);
    localparam logic [OUT_W-1:0] c_HI = OUT_W'((1 << (OUT_W - 1)) + HYST);
    localparam logic [PER_W-1:0] c_PER_MAX = {PER_W{1'b1}};

    logic [0:0]       r_state;
    logic             r_seen;
    logic [PER_W-1:0] r_cnt;
    logic [PER_W-1:0] r_period;
    logic             r_period_valid;
    logic             r_locked;

    logic [PER_W-1:0] w_cnt_inc;
    logic             w_rise;
    logic             w_timeout;

    always_comb begin
        w_cnt_inc = (r_cnt == c_PER_MAX) ? r_cnt : r_cnt + 1'b1;
        w_rise    = (r_state == S_WAIT_HIGH) && (w_sample >= c_HI);
        // Fires only on the sample that first hits the ceiling, so the FSM is
        // free to re-arm while the counter sits saturated.
        w_timeout = (r_cnt != c_PER_MAX) && (w_cnt_inc == c_PER_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_WAIT_LOW;
            r_seen         <= 1'b0;
            r_cnt          <= '0;
            r_period       <= '0;
            r_period_valid <= 1'b0;
            r_locked       <= 1'b0;
        end else begin
            r_period_valid <= 1'b0;
            if (w_frame_done) begin
                if (w_rise) begin
                    r_state <= S_WAIT_LOW;
                    r_cnt   <= '0;
                    r_seen  <= 1'b1;
                    if (r_seen) begin
                        r_period       <= w_cnt_inc;
                        r_period_valid <= 1'b1;
                        r_locked       <= 1'b1;
                    end
                end else if (w_timeout) begin
                    r_cnt    <= w_cnt_inc;
                    r_locked <= 1'b0;
                    r_seen   <= 1'b0;
                    r_state  <= S_WAIT_LOW;
                end else begin
                    r_cnt <= w_cnt_inc;
                    if ((r_state == S_WAIT_LOW) && (w_sample < c_LO)) begin
                        r_state <= S_WAIT_HIGH;
                    end
                end
            end
        end
    end

    assign period_out   = r_period;
    assign period_valid = r_period_valid;
    assign locked       = r_locked;
`else
    assign period_out   = '0;
    assign period_valid = 1'b0;
    assign locked       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sdm_tone_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdm_tone_rx
// Purpose  : Scoreboard bench for sdm_tone_rx (DECIM=16, OUT_W=8, PER_W=8).
// Revision : 1.0
// ============================================================================
module tb_sdm_tone_rx;

    localparam int DECIM = 16;
    localparam int OUT_W = 8;
    localparam int PER_W = 8;
    localparam int HYST  = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             bit_valid = 1'b0;
    logic             sdm_in = 1'b0;
    logic [OUT_W-1:0] sample_out;
    logic             sample_valid;
    logic [PER_W-1:0] period_out;
    logic             period_valid;
    logic             locked;

    typedef struct packed {
        logic [OUT_W-1:0] smp;
        logic             pv;
        logic [PER_W-1:0] per;
        logic             lk;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   bit_cnt = 0;

    sdm_tone_rx #(
        .DECIM(DECIM),
        .OUT_W(OUT_W),
        .PER_W(PER_W),
        .HYST (HYST)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bit_valid   (bit_valid),
        .sdm_in      (sdm_in),
        .sample_out  (sample_out),
        .sample_valid(sample_valid),
        .period_out  (period_out),
        .period_valid(period_valid),
        .locked      (locked)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp_v);
        n_tests++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Monitor: pops one expectation per sample strobe.
    always @(negedge clk) begin
        if (!rst) begin
            if (sample_valid) begin
                chk("strobe_align", ((bit_cnt != 0) && (bit_cnt % DECIM == 0)) ? 1 : 0, 1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("sample_out", int'(sample_out), int'(mon_e.smp));
                    chk("period_valid", int'(period_valid), int'(mon_e.pv));
                    chk("period_out", int'(period_out), int'(mon_e.per));
                    chk("locked", int'(locked), int'(mon_e.lk));
                end
            end else if (period_valid) begin
                chk("orphan_period_valid", 1, 0);
            end
        end
    end

    task automatic push(input int smp, input int pv, input int per, input int lk);
        exp_t e;
        e.smp = OUT_W'(smp);
        e.pv  = pv[0];
        e.per = PER_W'(per);
        e.lk  = lk[0];
        exp_q.push_back(e);
    endtask

    task automatic send_bit(input logic b, input int gap);
        repeat (gap) begin
            bit_valid = 1'b0;
            sdm_in    = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        bit_valid = 1'b1;
        sdm_in    = b;
        @(posedge clk); #1;
        bit_cnt++;
        bit_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        for (int c = 0; c < 3; c++) begin
            bit_valid = 1'($urandom_range(0, 1));
            sdm_in    = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("rst_sample_out", int'(sample_out), 0);
            chk("rst_sample_valid", int'(sample_valid), 0);
            chk("rst_period_out", int'(period_out), 0);
            chk("rst_period_valid", int'(period_valid), 0);
            chk("rst_locked", int'(locked), 0);
            @(posedge clk); #1;
        end
        bit_valid = 1'b0;
        sdm_in    = 1'b0;
        bit_cnt   = 0;
        rst       = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk("drain_outstanding", exp_q.size(), 0);
        exp_q.delete();
        repeat (4) begin @(posedge clk); #1; end
    endtask

    // Square-wave CIC output by phase, phase 0 = first sample after a 0->1 edge.
    function automatic int sq_val(input int p);
        if (p == 0)      return 136;
        else if (p < 8)  return 255;
        else if (p == 8) return 120;
        else             return 0;
    endfunction

    initial begin
        #1;
        do_reset();

        // Constant ones: transient then saturation.
        push(136, 0, 0, 0);
        for (int k = 0; k < 4; k++) push(255, 0, 0, 0);
        for (int n = 0; n < 80; n++) send_bit(1'b1, 0);
        drain();

        do_reset();
        for (int k = 0; k < 4; k++) push(0, 0, 0, 0);
        for (int n = 0; n < 64; n++) send_bit(1'b0, 0);
        drain();

        // Alternating 1,0 with random idle gaps.
        do_reset();
        push(72, 0, 0, 0);
        for (int k = 0; k < 7; k++) push(128, 0, 0, 0);
        for (int n = 0; n < 128; n++) send_bit((n % 2) == 0, $urandom_range(0, 2));
        drain();

        // A completed frame and a partial frame, each cut off by reset.
        do_reset();
        for (int n = 0; n < 16; n++) send_bit(1'b1, 0);
        do_reset();
        for (int n = 0; n < 7; n++) send_bit(1'b1, 0);
        do_reset();
        push(136, 0, 0, 0);
        push(255, 0, 0, 0);
        push(255, 0, 0, 0);
        for (int n = 0; n < 48; n++) send_bit(1'b1, 0);
        drain();

        do_reset();
`ifdef SDM_TONE_RX_PERIOD_EN
        for (int k = 1; k <= 370; k++) begin
            int v;
            int pv;
            int lk;
            if (k <= 64)       v = sq_val((k - 1) % 16);
            else if (k <= 330) v = (k == 65) ? 136 : 255;
            else               v = sq_val((k - 323) % 16);
            pv = (k == 34 || k == 50 || k == 66 || k == 356) ? 1 : 0;
            lk = ((k >= 34 && k < 321) || k >= 356) ? 1 : 0;
            push(v, pv, (k >= 34) ? 16 : 0, lk);
            for (int j = 1; j <= 16; j++) begin
                int  n;
                logic b;
                n = (k - 1) * 16 + j;
                if (k <= 64)       b = (((n - 1) / 128) % 2) == 0;
                else if (k <= 330) b = 1'b1;
                else               b = (((n - 5281) / 128) % 2) == 1;
                send_bit(b, 0);
            end
        end
`else
        for (int k = 1; k <= 48; k++) begin
            push(sq_val((k - 1) % 16), 0, 0, 0);
            for (int j = 1; j <= 16; j++) begin
                int n;
                n = (k - 1) * 16 + j;
                send_bit((((n - 1) / 128) % 2) == 0, 0);
            end
        end
`endif
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
